// File: rtl/uart_top.sv
// 8N2 UART transmitter: tx_start synchronizer and edge detector, baud tick counter, transmit FSM.
// tx_dout and tx_done are registered; the FSM computes their next values alongside the state.
module uart_top #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STOP_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx_dout,
    output logic                  tx_done
);

    localparam int unsigned BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV + 1);
    localparam int unsigned IDX_W    = $clog2(DATA_WIDTH + STOP_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      baud_cnt;
    logic [CNT_W-1:0]      baud_cnt_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  tx_dout_next;
    logic                  tx_done_next;
    logic                  sync_q1;
    logic                  sync_q2;
    logic                  sync_d;
    logic                  start_edge;
    logic                  bit_end;

    // Two-flop synchronizer plus delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_d  <= 1'b0;
        end else begin
            sync_q1 <= tx_start;
            sync_q2 <= sync_q1;
            sync_d  <= sync_q2;
        end
    end

    assign start_edge = sync_q2 & ~sync_d;
    assign bit_end    = (baud_cnt == CNT_W'(BAUD_DIV - 1));

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_dout  <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            tx_dout  <= tx_dout_next;
            tx_done  <= tx_done_next;
        end
    end

    // Next-state and next-output logic; bit_idx counts data bits, then stop bits
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        tx_dout_next  = tx_dout;
        tx_done_next  = 1'b0;

        if (state != IDLE) begin
            baud_cnt_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                tx_dout_next = 1'b1;
                if (start_edge) begin
                    shift_next    = data_in;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = START;
                    tx_dout_next  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    tx_dout_next = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift >> 1;
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                        tx_dout_next = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                        tx_dout_next = shift_next[0];
                    end
                end
            end
            STOP: begin
                tx_dout_next = 1'b1;
                if (bit_end) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_next = '0;
                        state_next   = IDLE;
                        tx_done_next = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                tx_dout_next = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_top.sv
// Directed and randomized frames for uart_top at a reduced baud divider, checked every
// cycle against a line model derived from the 8N2 frame format.
module tb_uart_top;

    localparam int unsigned DIV   = 10;
    localparam int unsigned DW    = 8;
    localparam int unsigned SB    = 2;
    localparam int          FRAME = (1 + DW + SB) * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] data_in;
    logic       tx_dout;
    logic       tx_done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_top #(
        .CLK_FREQ_HZ(1000),
        .BAUD_RATE  (100),
        .DATA_WIDTH (8),
        .STOP_BITS  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .data_in (data_in),
        .tx_dout (tx_dout),
        .tx_done (tx_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    endtask

    // Line level t clocks after the start-bit fall: start, data LSB first, stop bits
    function automatic logic model_bit(input logic [7:0] d, input int t);
        int idx;
        idx = t / int'(DIV);
        if (idx == 0) return 1'b0;
        if (idx <= int'(DW)) return d[idx-1];
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_dout[%0d]", tag, i), tx_dout, 1'b1);
            chk($sformatf("%s_done[%0d]", tag, i), tx_done, 1'b0);
        end
    endtask

    // Raise tx_start (or release reset with it already high) and check the whole frame
    task automatic frame(input logic [7:0] d, input bit from_reset, input int drop_at,
                         input int retrig_at, input bit scramble, input int tail,
                         input string tag);
        data_in = d;
        if (from_reset) rst_n = 1'b1;
        else tx_start = 1'b1;
        for (int c = 1; c <= 3 + FRAME + tail; c++) begin
            int t;
            step();
            t = c - 3;
            chk($sformatf("%s_dout[%0d]", tag, t), tx_dout,
                (t < 0 || t >= FRAME) ? 1'b1 : model_bit(d, t));
            chk($sformatf("%s_done[%0d]", tag, t), tx_done, (t == FRAME) ? 1'b1 : 1'b0);
            if (c == drop_at) tx_start = 1'b0;
            if (c == retrig_at) tx_start = 1'b1;
            if (scramble && (c % 7 == 0)) data_in = 8'($urandom);
        end
        tx_start = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passed);
        $fatal(1, "timeout");
    end

    initial begin
        int drop;
        logic [7:0] rnd;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        data_in  = 8'h00;
        idle(10, "reset");

        // tx_start already high at reset release; held high through and past the frame
        tx_start = 1'b1;
        step();
        frame(8'h76, 1'b1, 0, 0, 1'b0, 3 * DIV, "f76");
        idle(20, "gap1");

        frame(8'h3F, 1'b0, 20, 0, 1'b0, DIV, "f3F");
        idle(5, "gap2");

        // Second rising edge mid-frame must be ignored
        frame(8'hA5, 1'b0, 30, 35, 1'b0, 3 * DIV, "retrig");
        idle(5, "gap3");

        // data_in scrambled during the frame
        frame(8'hC3, 1'b0, 15, 0, 1'b1, DIV, "scram");
        idle(5, "gap4");

        for (int k = 0; k < 6; k++) begin
            rnd  = 8'($urandom);
            drop = int'($urandom_range(2, FRAME));
            frame(rnd, 1'b0, drop, 0, 1'b1, DIV, $sformatf("rnd%0d", k));
            idle(int'($urandom_range(3, 10)), $sformatf("rgap%0d", k));
        end

        // Abort an 8'h00 frame mid-DATA with an asynchronous reset
        data_in  = 8'h00;
        tx_start = 1'b1;
        repeat (3 + 4 * DIV + 3) step();
        chk("abort_pre_dout", tx_dout, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async_dout", tx_dout, 1'b1);
        chk("abort_async_done", tx_done, 1'b0);
        tx_start = 1'b0;
        idle(5, "abort_hold");
        rst_n = 1'b1;
        idle(3 * int'(DIV) + int'(FRAME), "abort_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
